// File: rtl/mii_uart_pkg.sv
// Shared types and constants for the MII-to-UART byte bridge.
// Covers the read-side FSM states, the FIFO entry layout and the ASCII helpers used by hex mode.
package mii_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACT,
    WAIT_DONE,
    SECOND
  } state_t;

  localparam int ENTRY_W    = 9;
  localparam int MARKER_BIT = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit for one nibble: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/mii_uart_bridge_sync_fifo.sv
// Power-of-two synchronous FIFO with registered read and a wrap-bit pointer scheme.
// A push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int ADDR_W = 7,
  parameter int WIDTH  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   fill
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr_reg;
  logic [ADDR_W:0]  rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign fill    = wr_ptr_reg - rd_ptr_reg;
  // Occupancy never exceeds DEPTH, so the top bit of fill is set only when full.
  assign full    = fill[ADDR_W];
  assign empty   = (fill == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
    if (pop_ok)  rd_data <= mem[rd_ptr_reg[ADDR_W-1:0]];
  end

endmodule

// File: rtl/mii_uart_bridge.sv
// Byte bridge from the MII assembler to uart_tx: edge-detected writes, FIFO buffering, paced output.
// Define MII_UART_HEX_ASCII_EN to send bytes as two ASCII hex characters and frame ends as CR,LF.
module mii_uart_bridge
  import mii_uart_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_rdy,
  input  logic [7:0]        in_q,
  input  logic              in_eof,
  input  logic              tx_active,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W:0]   fill,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic               rdy_prev_reg;
  logic               eof_pend_reg;
  logic               eof_pend_next;
  logic               rise;
  logic               wr_req;
  logic [ENTRY_W-1:0] wr_data;
  logic               push;
  logic               drop;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] entry;

  state_t             state_reg;
  state_t             state_next;
  logic [7:0]         tx_byte_reg;
  logic [7:0]         tx_byte_next;
`ifdef MII_UART_HEX_ASCII_EN
  logic [7:0]         lo_char_reg;
  logic [7:0]         lo_char_next;
  logic               second_reg;
  logic               second_next;
`endif

  // A data write wins the cycle; a coincident frame end waits one cycle as a pending marker.
  assign rise    = in_rdy & ~rdy_prev_reg;
  assign wr_req  = rise | eof_pend_reg | in_eof;
  assign wr_data = rise ? {1'b0, in_q} : {1'b1, 8'h00};
  assign push    = wr_req & ~full;
  assign drop    = wr_req & full;

  always_comb begin
    eof_pend_next = rise ? (eof_pend_reg | in_eof) : (eof_pend_reg & in_eof);
  end

  sync_fifo #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (entry),
    .full    (full),
    .empty   (empty),
    .fill    (fill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_prev_reg <= 1'b0;
      eof_pend_reg <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      rdy_prev_reg <= in_rdy;
      eof_pend_reg <= eof_pend_next;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // IDLE also waits for tx_active low so a strobe is never raised into a busy transmitter.
  always_comb begin
    state_next   = state_reg;
    tx_byte_next = tx_byte_reg;
    pop          = 1'b0;
    tx_dv        = 1'b0;
`ifdef MII_UART_HEX_ASCII_EN
    lo_char_next = lo_char_reg;
    second_next  = second_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!empty && !tx_active) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (entry[MARKER_BIT]) begin
`ifdef MII_UART_HEX_ASCII_EN
          tx_byte_next = ASCII_CR;
          lo_char_next = ASCII_LF;
          second_next  = 1'b1;
          state_next   = SEND;
`else
          state_next   = IDLE;
`endif
        end else begin
`ifdef MII_UART_HEX_ASCII_EN
          tx_byte_next = nibble_to_ascii(entry[7:4]);
          lo_char_next = nibble_to_ascii(entry[3:0]);
          second_next  = 1'b1;
`else
          tx_byte_next = entry[7:0];
`endif
          state_next   = SEND;
        end
      end
      SEND: begin
        tx_dv      = 1'b1;
        state_next = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (tx_active) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_active) begin
`ifdef MII_UART_HEX_ASCII_EN
          state_next = second_reg ? SECOND : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef MII_UART_HEX_ASCII_EN
      SECOND: begin
        tx_byte_next = lo_char_reg;
        second_next  = 1'b0;
        state_next   = SEND;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      tx_byte_reg <= 8'h00;
`ifdef MII_UART_HEX_ASCII_EN
      lo_char_reg <= 8'h00;
      second_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      tx_byte_reg <= tx_byte_next;
`ifdef MII_UART_HEX_ASCII_EN
      lo_char_reg <= lo_char_next;
      second_reg  <= second_next;
`endif
    end
  end

  assign tx_byte = tx_byte_reg;

endmodule

// File: tb/tb_mii_uart_bridge.sv
// Scoreboard bench for mii_uart_bridge (ADDR_W=3, DROP_W=4): stimulus queues expected UART bytes,
// a UART model/monitor pops and compares on every tx_dv. Follows MII_UART_HEX_ASCII_EN when defined.
module tb_mii_uart_bridge;

  localparam int ADDR_W = 3;
  localparam int DROP_W = 4;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int BUSY   = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_rdy = 1'b0;
  logic [7:0]        in_q = 8'h00;
  logic              in_eof = 1'b0;
  logic              tx_active;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic [ADDR_W:0]   fill;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  bit         force_busy = 1'b0;
  int         dv_seen = 0;
  int         last_dv_cyc = 0;
  int         last_rise_cyc = 0;
  bit         prev_dv = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] exp_q[$];
  int         model_fill = 0;
  int         model_drops = 0;

  mii_uart_bridge #(.ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_rdy    (in_rdy),
    .in_q      (in_q),
    .in_eof    (in_eof),
    .tx_active (tx_active),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign tx_active = force_busy | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hex_char(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
  endfunction

  // Reference behaviour of what the UART must see for one accepted FIFO entry.
  task automatic expect_entry(input bit marker, input logic [7:0] b);
`ifdef MII_UART_HEX_ASCII_EN
    if (marker) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(hex_char(int'(b) / 16));
      exp_q.push_back(hex_char(int'(b) % 16));
    end
`else
    if (!marker) exp_q.push_back(b);
`endif
  endtask

  // Model of a write while the bridge is kept from reading: first DEPTH entries fit, the rest drop.
  task automatic model_write(input bit marker, input logic [7:0] b, input bit stuck);
    if (!stuck || model_fill < DEPTH) begin
      expect_entry(marker, b);
      if (stuck) model_fill++;
    end else begin
      model_drops++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit eof_same, input int hold, input bit stuck);
    @(negedge clk);
    in_rdy = 1'b1;
    in_q   = b;
    in_eof = eof_same;
    last_rise_cyc = cyc;
    model_write(1'b0, b, stuck);
    if (eof_same) model_write(1'b1, 8'h00, stuck);
    @(negedge clk);
    in_eof = 1'b0;
    repeat (hold - 1) @(negedge clk);
    in_rdy = 1'b0;
    in_q   = 8'($urandom);
  endtask

  task automatic send_eof();
    @(negedge clk);
    in_eof = 1'b1;
    model_write(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    in_eof = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fill == 0 && !tx_active) break;
    end
    repeat (4) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_fill0"}, 32'(fill), 0);
  endtask

  // UART transmitter model and output monitor.
  always @(negedge clk) begin
    bit act_now;
    act_now = force_busy | (busy_cnt != 0);
    if (reset) begin
      busy_cnt = 0;
      prev_dv  = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) check("tx_byte_stable", tx_byte, cur_byte);
      end
      if (tx_dv) begin
        check("dv_spacing", 32'(prev_dv), 0);
        check("dv_while_active", 32'(act_now), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got byte %0h expected no transmission (cycle %0d)", tx_byte, cyc);
        end else begin
          check("tx_byte", tx_byte, exp_q.pop_front());
        end
        cur_byte    = tx_byte;
        busy_cnt    = BUSY;
        dv_seen++;
        last_dv_cyc = cyc;
      end
      prev_dv = tx_dv;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    int i;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_dv", 32'(tx_dv), 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two bytes, first-byte latency
    n0 = dv_seen;
    send_byte(8'h55, 1'b0, 1, 1'b0);
    for (i = 0; i < 20 && dv_seen == n0; i++) @(negedge clk);
    check("first_dv_latency", 32'(last_dv_cyc - last_rise_cyc), 3);
    send_byte(8'hAA, 1'b0, 2, 1'b0);
    wait_drain("two_bytes");

    // Long in_rdy high period produces exactly one entry
    force_busy = 1'b1;
    send_byte(8'h12, 1'b0, 50, 1'b0);
    repeat (3) @(negedge clk);
    check("long_rdy_fill", 32'(fill), 1);
    force_busy = 1'b0;
    wait_drain("long_rdy");

    // Data and frame end in the same cycle
    send_byte(8'h3A, 1'b1, 1, 1'b0);
    wait_drain("data_eof_same");

    // Randomized bursts of bytes and frame ends, drained between bursts
    for (int burst = 0; burst < 8; burst++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        send_byte(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 4), 1'b0);
        if ($urandom_range(0, 3) == 0) send_eof();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("random_burst");
    end

    // Overflow with the transmitter stuck busy, then drop counter saturation
    force_busy  = 1'b1;
    model_fill  = 0;
    model_drops = 0;
    for (int k = 0; k < 10; k++) send_byte(8'(8'h20 + k), 1'b0, 1, 1'b1);
    repeat (2) @(negedge clk);
    check("ovf_fill", 32'(fill), 32'(model_fill));
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(model_drops));
    check("ovf_flag", 32'(overflow), 32'(model_drops > 0));
    for (int k = 0; k < 18; k++) send_byte(8'($urandom), 1'b0, 1, 1'b1);
    repeat (2) @(negedge clk);
    check("sat_drop_cnt", 32'(drop_cnt), 32'((model_drops > 15) ? 15 : model_drops));
    check("sat_fill", 32'(fill), 32'(model_fill));
    force_busy = 1'b0;
    model_fill = 0;
    wait_drain("ovf_release");
    check("ovf_flag_sticky", 32'(overflow), 1);

    // Asynchronous reset while waiting on the transmitter with entries queued
    n0 = dv_seen;
    send_byte(8'hC3, 1'b0, 1, 1'b0);
    for (i = 0; i < 20 && dv_seen == n0; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h60 + k), 1'b0, 1, 1'b0);
    @(negedge clk);
    check("pre_reset_fill", 32'(fill), 5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx_dv", 32'(tx_dv), 0);
    check("async_rst_fill", 32'(fill), 0);
    check("async_rst_overflow", 32'(overflow), 0);
    check("async_rst_drop_cnt", 32'(drop_cnt), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h7E, 1'b1, 3, 1'b0);
    wait_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
